// File: rtl/i2f_pkg.sv
// Shared float-format constants, the single-precision field layout and a
// constant-evaluable clog2 for the integer-to-float scheduler.
package i2f_pkg;

    localparam int FLT_W    = 32;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } flt_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) r = int'(i) + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/i2f_core.sv
// Combinational 32-bit two's-complement to IEEE-754 single converter.
// Mantissa is truncated toward zero; there is no rounding.
module i2f_core
    import i2f_pkg::*;
(
    input  logic [FLT_W-1:0] int_in,
    output flt_t             flt_out
);

    logic [FLT_W-1:0] mag;
    logic [FLT_W-1:0] norm;
    logic [4:0]       msb;

    always_comb begin
        mag = int_in[FLT_W-1] ? (~int_in + 32'd1) : int_in;

        msb = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (mag[i]) msb = i[4:0];
        end

        // Shift the leading one up to bit 31; the next 23 bits are the mantissa.
        norm = mag << (5'd31 - msb);

        flt_out = '0;
        if (int_in != '0) begin
            flt_out.sign = int_in[FLT_W-1];
            flt_out.exp  = EXP_W'(msb) + EXP_W'(EXP_BIAS);
            flt_out.mant = norm[FLT_W-2 -: MANT_W];
        end
    end

endmodule

// File: rtl/i2f_rr_scheduler.sv
// Round-robin scheduler sharing one int-to-float converter among NUM_REQ
// requesters; two-stage pipeline (operand latch, converted output register).
module i2f_rr_scheduler
    import i2f_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*FLT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [FLT_W-1:0]         out_data,
    output logic [ID_W-1:0]          out_id,
    input  logic                     out_ready
);

    localparam int          ID_W_REQ = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);
    localparam int unsigned N        = NUM_REQ;

    generate
        if (ID_W != ID_W_REQ || NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_cfg
            $error("i2f_rr_scheduler: NUM_REQ must be 2..16 and ID_W must equal clog2(NUM_REQ)");
        end
    endgenerate

    logic [ID_W-1:0]  rr_ptr;
    logic             s1_valid;
    logic [FLT_W-1:0] s1_data;
    logic [ID_W-1:0]  s1_id;

    logic             s2_free;
    logic             s1_free;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_idx;
    logic [FLT_W-1:0] grant_data;
    logic [ID_W-1:0]  rr_next;
    flt_t             conv;

    assign s2_free = !out_valid || out_ready;
    assign s1_free = !s1_valid || s2_free;

    // Search from rr_ptr upward, wrapping at NUM_REQ; first valid wins.
    always_comb begin
        int unsigned     cand;
        logic [ID_W-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (s1_free && !rst) begin
            for (int unsigned off = 0; off < N; off++) begin
                cand = 32'(rr_ptr) + off;
                if (cand >= N) cand = cand - N;
                cand_idx = cand[ID_W-1:0];
                if (!grant_valid && req_valid[cand_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant_idx == ID_W'(k)) grant_data = req_data[k*FLT_W +: FLT_W];
        end
    end

    assign req_ready = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    assign rr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    i2f_core u_core (
        .int_in  (s1_data),
        .flt_out (conv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_id     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            if (grant_valid) rr_ptr <= rr_next;

            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= conv;
                    out_id   <= s1_id;
                end
            end

            if (s1_free) begin
                s1_valid <= grant_valid;
                if (grant_valid) begin
                    s1_data <= grant_data;
                    s1_id   <= grant_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2f_rr_scheduler.sv
// Directed bench for i2f_rr_scheduler: conversion vector table plus
// hand-written streaming, backpressure, pointer-wrap and reset sequences.
module tb_i2f_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic [31:0]          out_data;
    logic [ID_W-1:0]      out_id;
    logic                 out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    i2f_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    typedef struct {
        int unsigned req;
        logic [31:0] din;
        logic [31:0] flt;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] strm_flt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    initial begin
        int accepted;

        vecs[0] = '{1, 32'h0000_0005, 32'h40A0_0000};
        vecs[1] = '{0, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{0, 32'h0000_0001, 32'h3F80_0000};
        vecs[3] = '{0, 32'hFFFF_FFFF, 32'hBF80_0000};
        vecs[4] = '{0, 32'hFFFF_FFF8, 32'hC100_0000};
        vecs[5] = '{0, 32'h7FFF_FFFF, 32'h4EFF_FFFF};
        vecs[6] = '{0, 32'h8000_0000, 32'hCF00_0000};
        vecs[7] = '{3, 32'h0001_0000, 32'h4780_0000};
        vecs[8] = '{2, 32'h00FF_FFFF, 32'h4B7F_FFFF};
        vecs[9] = '{1, 32'h01FF_FFFF, 32'h4BFF_FFFF};

        strm_flt[0] = 32'h4120_0000;  // 10
        strm_flt[1] = 32'h4130_0000;  // 11
        strm_flt[2] = 32'h4140_0000;  // 12
        strm_flt[3] = 32'h4150_0000;  // 13

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data,       32'd0);
        check("rst_out_id",    32'(out_id),    32'd0);
        rst = 1'b0;

        // Conversion table: one request at a time, 2-cycle latency.
        for (int i = 0; i < 10; i++) begin
            req_valid = 4'b0001 << vecs[i].req;
            req_data[32*vecs[i].req +: 32] = vecs[i].din;
            #1 check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(4'b0001 << vecs[i].req));
            @(negedge clk);
            req_valid = '0;
            #1 check($sformatf("vec%0d_bubble", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_data", i),  out_data,       vecs[i].flt);
            check($sformatf("vec%0d_id", i),    32'(out_id),    vecs[i].req);
        end

        // Streaming with all requesters valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) req_data[32*k +: 32] = 32'(k + 10);
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1 check($sformatf("strm%0d_ready", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
            if (c >= 2) begin
                check($sformatf("strm%0d_valid", c), 32'(out_valid), 32'd1);
                check($sformatf("strm%0d_id", c),    32'(out_id),    32'((c - 2) % 4));
                check($sformatf("strm%0d_data", c),  out_data,       strm_flt[(c - 2) % 4]);
            end
            @(negedge clk);
        end

        // Backpressure: out_ready low for 5 cycles.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ((req_valid & req_ready) != '0) accepted++;
            if (c >= 2) begin
                check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
                check($sformatf("bp%0d_id", c),    32'(out_id),    32'd0);
                check($sformatf("bp%0d_data", c),  out_data,       strm_flt[0]);
                check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
            end
            @(negedge clk);
        end
        check("bp_accepted", 32'(accepted), 32'd2);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 check($sformatf("rel%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("rel%0d_id", c),   32'(out_id), 32'(c % 4));
            check($sformatf("rel%0d_data", c), out_data,    strm_flt[c % 4]);
            @(negedge clk);
        end

        // rr_ptr wrap: grant req 2 leaves rr_ptr=3; then reqs 0 and 2 valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b0100;
        #1 check("wrap_pre_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b0101;
        #1 check("wrap_first_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        #1 check("wrap_second_ready", 32'(req_ready), 32'b0100);

        // Reset with both stages full.
        out_ready = 1'b0;
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        check("mid_full_valid", 32'(out_valid), 32'd1);
        check("mid_full_ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  out_data,       32'd0);
        check("mid_rst_id",    32'(out_id),    32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
